// File: rtl/mdu_pkg.sv
// Shared opcode encoding, state type and helpers for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage to multiply/divide unit connection: issue side from the pipeline, HI/LO and busy back.
// Handshake: start/we_hilo are single-cycle pulses, legal only while md_hazard=0; busy and HI/LO are registered.
interface mdu_if;
  import mdu_pkg::*;

  logic        start;
  md_op_e      md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        we_hilo;
  logic        busy;
  logic        md_hazard;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, md_op, A, B, we_hilo,
    input  busy, md_hazard, HI, LO
  );

  modport slave (
    input  start, md_op, A, B, we_hilo,
    output busy, md_hazard, HI, LO
  );

endinterface

// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO: fixed-latency MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO.
// Results are computed combinationally from latched operands; the counter only delays the write.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic      clk,
  input  logic      reset,
  mdu_if.slave      m,
  output md_state_e o_dbg_state
);

  localparam int unsigned CNT_W = $clog2(max2(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  md_op_e           r_op;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_mag_q;
  logic [31:0] w_mag_r;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [63:0] w_res;
  logic        w_res_we;
  logic        w_busy;
  logic        w_is_div;

  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide via magnitudes so 0x80000000 / -1 cannot overflow the divider.
  assign w_abs_a = r_a[31] ? (32'd0 - r_a) : r_a;
  assign w_abs_b = r_b[31] ? (32'd0 - r_b) : r_b;
  assign w_mag_q = w_abs_a / w_abs_b;
  assign w_mag_r = w_abs_a % w_abs_b;
  assign w_q_s   = (r_a[31] ^ r_b[31]) ? (32'd0 - w_mag_q) : w_mag_q;
  assign w_r_s   = r_a[31] ? (32'd0 - w_mag_r) : w_mag_r;

  always_comb begin
    w_res    = {r_hi, r_lo};
    w_res_we = 1'b0;
    case (r_op)
      MD_MULT:  begin w_res = w_prod_s;                 w_res_we = 1'b1;          end
      MD_MULTU: begin w_res = w_prod_u;                 w_res_we = 1'b1;          end
      MD_DIV:   begin w_res = {w_r_s, w_q_s};           w_res_we = (r_b != '0);   end
      MD_DIVU:  begin w_res = {r_a % r_b, r_a / r_b};   w_res_we = (r_b != '0);   end
      default:  begin w_res = {r_hi, r_lo};             w_res_we = 1'b0;          end
    endcase
  end

  assign w_is_div = (m.md_op == MD_DIV) || (m.md_op == MD_DIVU);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= MD_MULT;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // start has priority over a simultaneous we_hilo
          if (m.start) begin
            r_a     <= m.A;
            r_b     <= m.B;
            r_op    <= m.md_op;
            r_cnt   <= w_is_div ? DIV_LOAD : MULT_LOAD;
            r_state <= ST_RUN;
          end else if (m.we_hilo) begin
            if (m.md_op == MD_MTHI) r_hi <= m.A;
            else if (m.md_op == MD_MTLO) r_lo <= m.A;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            if (w_res_we) {r_hi, r_lo} <= w_res;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_busy      = (r_state == ST_RUN);
  assign m.busy      = w_busy;
  assign m.md_hazard = m.start | w_busy;
  assign m.HI        = r_hi;
  assign m.LO        = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed and random operations, reference model feeds an expected queue, monitor checks completions.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic      clk = 1'b0;
  logic      rst_n;
  md_state_e dbg_state;

  mdu_if m ();

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .m           (m.slave),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result from 64-bit integer arithmetic; divide by zero keeps HI/LO.
  function automatic logic [63:0] ref_result(input md_op_e op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return 64'(ua * ub);
      MD_DIV: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 32'd0) return {hi, lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // Monitor: every falling edge of busy is a completed operation.
  initial begin : monitor
    logic        prev_busy;
    logic [63:0] e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !m.busy) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL result_unexpected: got %h expected none", {m.HI, m.LO});
          end else begin
            e = exp_q.pop_front();
            chk("result_hilo", {m.HI, m.LO}, e);
          end
        end
        prev_busy = m.busy;
      end
    end
  end

  // Called at a negedge; returns at the negedge where busy has fallen.
  task automatic run_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    logic [63:0] e;
    int          n_busy, gaps, exp_n;
    logic        bz, hz;
    e = ref_result(op, a, b, model_hi, model_lo);
    exp_q.push_back(e);
    {model_hi, model_lo} = e;
    exp_n = (op == MD_DIV || op == MD_DIVU) ? DC : MC;
    m.start = 1'b1; m.we_hilo = 1'b0; m.md_op = op; m.A = a; m.B = b;
    #1;
    chk("hazard_on_start", 64'(m.md_hazard), 64'd1);
    @(posedge clk);
    #1;
    m.start = 1'b0;
    n_busy = 0;
    gaps = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bz = m.busy;
      hz = m.md_hazard;
      if (!bz) break;
      n_busy++;
      if (!hz) gaps++;
      if (inject && n_busy == 2) begin
        m.start = 1'b1; m.we_hilo = 1'b1; m.md_op = MD_MTHI;
        m.A = $urandom; m.B = $urandom;
      end else begin
        m.start = 1'b0; m.we_hilo = 1'b0;
      end
    end
    m.start = 1'b0; m.we_hilo = 1'b0;
    chk("busy_cycles", 64'(n_busy), 64'(exp_n));
    chk("hazard_gap", 64'(gaps), 64'd0);
  endtask

  task automatic mt(input md_op_e op, input logic [31:0] a);
    m.we_hilo = 1'b1; m.start = 1'b0; m.md_op = op; m.A = a;
    if (op == MD_MTHI) model_hi = a; else model_lo = a;
    @(posedge clk);
    #1;
    m.we_hilo = 1'b0;
    @(negedge clk);
    chk("mt_busy", 64'(m.busy), 64'd0);
    chk("mt_hilo", {m.HI, m.LO}, {model_hi, model_lo});
  endtask

  task automatic abort_div();
    int errs;
    m.start = 1'b1; m.we_hilo = 1'b0; m.md_op = MD_DIV; m.A = 32'd100; m.B = 32'd7;
    @(posedge clk);
    #1;
    m.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", 64'(m.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(m.busy), 64'd0);
    chk("abort_hilo", {m.HI, m.LO}, 64'd0);
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    errs = 0;
    repeat (15) begin
      @(negedge clk);
      if (m.busy || m.HI != 32'd0 || m.LO != 32'd0) errs++;
    end
    chk("abort_no_write", 64'(errs), 64'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    md_op_e      op;
    logic [31:0] a, b;
    m.start = 1'b0; m.we_hilo = 1'b0; m.md_op = MD_MULT; m.A = '0; m.B = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(m.busy), 64'd0);
    chk("reset_hilo", {m.HI, m.LO}, 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    #2;
    rst_n = 1'b1;
    @(negedge clk);

    run_md(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_neg", {m.HI, m.LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_max", {m.HI, m.LO}, 64'h0000_0001_FFFF_FFFE);
    run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg", {m.HI, m.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);
    run_md(MD_DIVU, 32'd7, 32'd0, 1'b0);
    chk("divu_by_zero", {m.HI, m.LO}, 64'h0000_0011_0000_0022);
    mt(MD_MTHI, 32'h1234);
    mt(MD_MTLO, 32'h5678);
    chk("mthi_mtlo", {m.HI, m.LO}, 64'h0000_1234_0000_5678);
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_overflow", {m.HI, m.LO}, 64'h0000_0000_8000_0000);
    run_md(MD_MULT, 32'd1000, 32'hFFFF_FF00, 1'b1);

    abort_div();
    chk("after_abort_state", 64'(dbg_state), 64'(ST_IDLE));

    run_md(MD_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    run_md(MD_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);

    for (int i = 0; i < 24; i++) begin
      op = md_op_e'(3'($urandom_range(0, 5)));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = {28'd0, 4'($urandom_range(1, 15))};
      if (op == MD_MTHI || op == MD_MTLO) mt(op, a);
      else run_md(op, a, b, $urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("final_hilo", {m.HI, m.LO}, {model_hi, model_lo});
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the E stage of the five-stage pipeline, owning the HI/LO registers. It executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and performs MTHI/MTLO in one cycle. It drives the busy indication that the D-stage hazard logic consumes to hold HI/LO-touching instructions in D.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  E-stage instruction is MULT/MULTU/DIV/DIVU; one-cycle pulse
- md_op  input  3  operation code from the shared `param.v` encoding
- A  input  32  rs operand (forwarded value)
- B  input  32  rt operand (forwarded value)
- we_hilo  input  1  E-stage instruction is MTHI/MTLO; selects the target by md_op
- busy  output  1  registered; operation in progress
- md_hazard  output  1  combinational start | busy; feeds the D-stage stall unit
- HI  output  32  registered HI
- LO  output  32  registered LO

## Operation
- Opcodes: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- Idle (busy=0), start=1:
  - latch A, B and md_op;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - the unit enters Run.
- Run (busy=1):
  - counter decrements each cycle;
  - on the edge where the counter goes 1->0, write the result to HI/LO and return to Idle.
- Results:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
- Boundary cases:
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero (B=0): the full DIV_CYCLES busy period still runs, and HI/LO are left unchanged.
- MTHI/MTLO:
  - when we_hilo=1 and the unit is Idle, write A into HI or LO at the next edge;
  - busy stays 0.
- Protocol and illegal inputs:
  - The hazard logic guarantees no start, we_hilo or MFHI/MFLO reaches E while md_hazard=1.
  - If start or we_hilo arrives while busy=1 anyway, it is ignored. The running operation is unaffected.
  - If start and we_hilo are both 1 in the same cycle, start wins and we_hilo is ignored.
- Consumer rule: the stall unit stalls D when the D instruction is any MD/MF/MT instruction and md_hazard=1.

## Timing
- Reset values: busy=0, HI=0, LO=0, counter=0, latched operands=0.
- Reset asserted mid-operation aborts the operation: busy=0 and HI=LO=0 immediately, with no result write.
- Start at the cycle-t edge:
  - busy=1 for cycles t+1 through t+N, where N = MULT_CYCLES or DIV_CYCLES;
  - new HI/LO are visible in cycle t+N+1, the same cycle busy returns to 0.
- md_hazard is high in cycle t (via start) and in cycles t+1..t+N (via busy), so no gap appears to the stall unit.
- A start is accepted in the cycle immediately after busy falls (back-to-back operations).
- MTHI/MTLO take effect at the next edge. HI/LO are read combinationally by MFHI/MFLO in E.

## Structure
- The MD_* opcode constants go in the shared `param.v`, alongside the existing pipeline constants.
- Single module, no sub-module:
  - the product and quotient are computed combinationally from the latched operands;
  - only the result write is delayed by the counter.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

## Test plan
- Reset low, then release. Required: busy=0, HI=0, LO=0. Then MULT A=0xFFFFFFFE (-2), B=3:
  - busy high for exactly 5 cycles;
  - afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=2: after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2:
  - busy high for 10 cycles;
  - afterwards LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0, with HI=0x11, LO=0x22 beforehand: busy high for 10 cycles, and HI/LO are still 0x11/0x22 afterwards.
- MTHI A=0x1234, then the next cycle MTLO A=0x5678: HI=0x1234, LO=0x5678, and busy never asserts.
- Pulse reset low in the 3rd busy cycle of a DIV: busy=0 and HI=LO=0 immediately, and no later write occurs. A start in the cycle busy falls after a MULT must be accepted.
